// File: rtl/pop_seq_pkg.sv
// Shared types and constants for the pop_sequencer pulse timing block.
// FSM state encoding, configuration register map and default sizing.
package pop_seq_pkg;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_WIDTH  = 16;

    localparam logic [7:0] ADDR_PERIOD  = 8'd0;
    localparam logic [7:0] ADDR_CYCLES  = 8'd1;
    localparam logic [7:0] ADDR_CH_BASE = 8'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } pop_seq_state_t;

    // Channel k owns addresses ADDR_CH_BASE+2k (start) and ADDR_CH_BASE+2k+1 (stop)
    function automatic logic addr_in_range(input logic [7:0] addr, input int num_ch);
        return ({1'b0, addr} < ({1'b0, ADDR_CH_BASE} + 9'(2 * num_ch)));
    endfunction

endpackage

// File: rtl/pop_seq_channel.sv
// One timing channel: decides from the period count whether its pulse window is open.
// Supports plain windows, windows wrapping across the period boundary, and disabled (start = stop).
import pop_seq_pkg::*;

module pop_seq_channel #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] start,
    input  logic [WIDTH-1:0] stop,
    input  logic [WIDTH-1:0] period,
    input  logic             en,
    output logic             pulse
);

    // A start value that the count never reaches keeps the channel quiet all period
    always_comb begin
        pulse = 1'b0;
        if (!en || (start >= period) || (start == stop)) begin
            pulse = 1'b0;
        end else if (start < stop) begin
            pulse = (count >= start) && (count < stop);
        end else begin
            pulse = (count >= start) || (count < stop);
        end
    end

endmodule

// File: rtl/pop_sequencer.sv
// Multi-channel pulse sequencer with shadowed timing registers and single/free-running modes.
// Build macro POP_SEQ_TRIG_EN adds a synchronised trig input that gates the start of every period.
import pop_seq_pkg::*;

module pop_sequencer #(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              single,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
`ifdef POP_SEQ_TRIG_EN
    input  logic              trig,
`endif
    output logic [NUM_CH-1:0] ch_out,
    output logic              busy,
    output logic              period_tick,
    output logic              cfg_err
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    pop_seq_state_t    state_r;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  cyc_left_r;
    logic [NUM_CH-1:0] ch_out_r;
    logic              busy_r;
    logic              tick_r;
    logic              cfg_err_r;

    logic [WIDTH-1:0]  period_sh_r;
    logic [WIDTH-1:0]  cycles_sh_r;
    logic [WIDTH-1:0]  start_sh_r [NUM_CH];
    logic [WIDTH-1:0]  stop_sh_r  [NUM_CH];
    logic [WIDTH-1:0]  period_a_r;
    logic [WIDTH-1:0]  start_a_r  [NUM_CH];
    logic [WIDTH-1:0]  stop_a_r   [NUM_CH];

    logic [NUM_CH-1:0] pulse_s;
    logic              run_en_s;
    logic              wrap_s;
    logic              arm_s;
    logic              zero_arm_s;
    logic              copy_s;
    logic              bad_addr_s;
    logic              trig_edge_s;
    logic              trig_mode_s;

`ifdef POP_SEQ_TRIG_EN
    logic [2:0] trig_sync_r;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_sync_r <= 3'b000;
        end else begin
            trig_sync_r <= {trig_sync_r[1:0], trig};
        end
    end

    assign trig_edge_s = trig_sync_r[1] & ~trig_sync_r[2];
    assign trig_mode_s = 1'b1;
`else
    assign trig_edge_s = 1'b1;
    assign trig_mode_s = 1'b0;
`endif

    assign run_en_s   = (state_r == RUN);
    assign wrap_s     = run_en_s && (count_r == (period_a_r - CNT_ONE));
    assign arm_s      = (state_r == IDLE) && run && (period_sh_r != CNT_ZERO);
    assign zero_arm_s = (state_r == IDLE) && run && (period_sh_r == CNT_ZERO);
    assign copy_s     = arm_s || wrap_s;
    assign bad_addr_s = cfg_we && !addr_in_range(cfg_addr, NUM_CH);

    // Configuration writes land in the shadow bank only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_sh_r <= CNT_ZERO;
            cycles_sh_r <= CNT_ZERO;
            for (int k = 0; k < NUM_CH; k++) begin
                start_sh_r[k] <= CNT_ZERO;
                stop_sh_r[k]  <= CNT_ZERO;
            end
        end else if (cfg_we) begin
            if (cfg_addr == ADDR_PERIOD) begin
                period_sh_r <= cfg_data;
            end else if (cfg_addr == ADDR_CYCLES) begin
                cycles_sh_r <= cfg_data;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (cfg_addr == (ADDR_CH_BASE + 8'(2 * k))) begin
                        start_sh_r[k] <= cfg_data;
                    end else if (cfg_addr == (ADDR_CH_BASE + 8'(2 * k + 1))) begin
                        stop_sh_r[k] <= cfg_data;
                    end
                end
            end
        end
    end

    // Shadow-to-active transfer at arm and each boundary; a write in the same cycle waits a period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_a_r <= CNT_ZERO;
            for (int k = 0; k < NUM_CH; k++) begin
                start_a_r[k] <= CNT_ZERO;
                stop_a_r[k]  <= CNT_ZERO;
            end
        end else if (copy_s) begin
            // A zero period would never wrap, so the running period is kept instead
            if (period_sh_r != CNT_ZERO) begin
                period_a_r <= period_sh_r;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                start_a_r[k] <= start_sh_r[k];
                stop_a_r[k]  <= stop_sh_r[k];
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err_r <= 1'b0;
        end else if (bad_addr_s || zero_arm_s) begin
            cfg_err_r <= 1'b1;
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < NUM_CH; gk++) begin : g_ch
            pop_seq_channel #(.WIDTH(WIDTH)) u_ch (
                .count  (count_r),
                .start  (start_a_r[gk]),
                .stop   (stop_a_r[gk]),
                .period (period_a_r),
                .en     (run_en_s),
                .pulse  (pulse_s[gk])
            );
        end
    endgenerate

    // Sequencer FSM, period counter and registered outputs (outputs trail the count by one clock)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            count_r    <= CNT_ZERO;
            cyc_left_r <= CNT_ZERO;
            ch_out_r   <= {NUM_CH{1'b0}};
            busy_r     <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            tick_r   <= wrap_s;
            ch_out_r <= run_en_s ? pulse_s : {NUM_CH{1'b0}};
            case (state_r)
                IDLE: begin
                    count_r <= CNT_ZERO;
                    if (arm_s) begin
                        state_r    <= ARMED;
                        busy_r     <= 1'b1;
                        cyc_left_r <= cycles_sh_r;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ARMED: begin
                    count_r <= CNT_ZERO;
                    if (trig_edge_s) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else if (!run) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (wrap_s) begin
                        count_r <= CNT_ZERO;
                        if (!run) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        // cycle_count of 0 or 1 both end after this period
                        end else if (single && (cyc_left_r <= CNT_ONE)) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                        end else begin
                            if (single) begin
                                cyc_left_r <= cyc_left_r - CNT_ONE;
                            end
                            state_r <= trig_mode_s ? ARMED : RUN;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        count_r <= count_r + CNT_ONE;
                        busy_r  <= 1'b1;
                    end
                end
                DONE: begin
                    count_r <= CNT_ZERO;
                    busy_r  <= 1'b0;
                    if (!run) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ch_out      = ch_out_r;
    assign busy        = busy_r;
    assign period_tick = tick_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_pop_sequencer.sv
// Self-checking bench for pop_sequencer (default build, no trigger input).
// Expected outputs come from window arithmetic over cycles elapsed since run was raised.
module tb_pop_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        single;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [3:0]  ch_out;
    logic        busy;
    logic        period_tick;
    logic        cfg_err;

    int total;
    int bad;

    // Reference configuration of the run under test
    int per;
    int cyc;
    int st [4];
    int sp [4];
    int n_per;
    int jw;
    int new_stop0;

    pop_sequencer #(.NUM_CH(4), .WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .single      (single),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .ch_out      (ch_out),
        .busy        (busy),
        .period_tick (period_tick),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Window open when the offset from start, modulo the period, is shorter than the window length
    function automatic bit ref_pulse(input int c, input int st_v, input int sp_v, input int p);
        int len;
        if (st_v >= p) return 1'b0;
        len = (sp_v >= p) ? (p - st_v) : ((sp_v - st_v + p) % p);
        return ((c - st_v + p) % p) < len;
    endfunction

    // Sample j is taken just after the j-th clock edge following run rising;
    // the displayed count is j-3 and period m uses the rewritten stop0 only if its copy edge follows the write
    function automatic logic [3:0] ref_ch(input int j);
        logic [3:0] v;
        int g;
        int m;
        int spk;
        v = 4'b0000;
        if (j >= 3 && j <= n_per * per + 2) begin
            g = j - 3;
            m = g / per;
            for (int k = 0; k < 4; k++) begin
                spk = sp[k];
                if (k == 0 && (m * per + 1 > jw)) spk = new_stop0;
                v[k] = ref_pulse(g % per, st[k], spk, per);
            end
        end
        return v;
    endfunction

    function automatic logic ref_tick(input int j);
        return (j >= 3) && (j <= n_per * per + 2) && (((j - 3) % per) == per - 1);
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic write_cfg();
        cfg_write(8'd0, 16'(per));
        cfg_write(8'd1, 16'(cyc));
        for (int k = 0; k < 4; k++) begin
            cfg_write(8'(2 + 2 * k), 16'(st[k]));
            cfg_write(8'(3 + 2 * k), 16'(sp[k]));
        end
    endtask

    task automatic run_seq(input bit sgl, input int jd_v);
        int ticks;
        int lim;
        single = sgl;
        if (sgl) begin
            n_per = (cyc < 1) ? 1 : cyc;
        end else begin
            n_per = 1;
            while (n_per * per + 1 < jd_v) n_per++;
        end
        lim   = n_per * per + 6;
        ticks = 0;
        run   = 1'b1;
        for (int j = 1; j <= lim; j++) begin
            @(posedge clk);
            #1;
            chk("ch_out", 32'(ch_out), 32'(ref_ch(j)));
            chk("busy", 32'(busy), (j <= n_per * per + 1) ? 32'd1 : 32'd0);
            chk("period_tick", 32'(period_tick), 32'(ref_tick(j)));
            if (period_tick) ticks++;
            if (j == jw) begin
                cfg_we   = 1'b1;
                cfg_addr = 8'd3;
                cfg_data = 16'(new_stop0);
            end else begin
                cfg_we = 1'b0;
            end
            if (!sgl && j == jd_v) run = 1'b0;
        end
        chk("tick_count", 32'(ticks), 32'(n_per));
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ch_out", 32'(ch_out), 32'd0);
        chk("no_cfg_err", 32'(cfg_err), 32'd0);
        jw = 1 << 30;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; run = 1'b0; single = 1'b0;
        cfg_we = 1'b0; cfg_addr = 8'd0; cfg_data = 16'd0;
        jw = 1 << 30; new_stop0 = 0;

        // Reset takes effect without a clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_ch_out", 32'(ch_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Free-running, period 400, two plain windows
        per = 400; cyc = 0;
        st = '{10, 0, 0, 300};
        sp = '{60, 0, 0, 310};
        write_cfg();
        run_seq(1'b0, 600);

        // Wrap-around window, disabled window, out-of-period start and stop
        per = 100;
        st = '{150, 90, 20, 40};
        sp = '{30, 5, 20, 200};
        write_cfg();
        run_seq(1'b0, 150);

        // Single mode, three periods of 50
        per = 50; cyc = 3;
        st = '{5, 45, 0, 10};
        sp = '{15, 3, 49, 10};
        write_cfg();
        run_seq(1'b1, 0);

        // cycle_count 0 still runs one period
        per = 7; cyc = 0;
        st = '{0, 6, 2, 3};
        sp = '{1, 0, 5, 9};
        write_cfg();
        run_seq(1'b1, 0);

        // stop0 rewritten mid-period takes effect on the next period
        per = 400; cyc = 0;
        st = '{10, 0, 0, 300};
        sp = '{60, 0, 0, 310};
        write_cfg();
        jw = 100; new_stop0 = 80;
        run_seq(1'b0, 600);

        // Write coinciding with the boundary copy waits one more period
        per = 50;
        st = '{10, 0, 0, 0};
        sp = '{20, 0, 0, 0};
        write_cfg();
        jw = 51; new_stop0 = 30;
        run_seq(1'b0, 140);

        // Randomised configurations
        for (int it = 0; it < 6; it++) begin
            per = int'($urandom_range(2, 60));
            cyc = int'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                st[k] = int'($urandom_range(0, per + 3));
                sp[k] = int'($urandom_range(0, per + 3));
            end
            write_cfg();
            if ($urandom_range(0, 1) == 1) run_seq(1'b1, 0);
            else run_seq(1'b0, int'($urandom_range(per + 2, 3 * per)));
        end

        // Address range and sticky error flag
        cfg_write(8'd9, 16'd5);
        chk("addr9_ok", 32'(cfg_err), 32'd0);
        cfg_write(8'd10, 16'd5);
        chk("addr10_err", 32'(cfg_err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 32'(cfg_err), 32'd1);

        // Reset 37 cycles into RUN, then re-arm attempt on zeroed registers
        per = 400; cyc = 0;
        st = '{10, 0, 0, 300};
        sp = '{60, 0, 0, 310};
        write_cfg();
        single = 1'b0;
        run = 1'b1;
        repeat (39) @(posedge clk);
        #1;
        chk("pre_rst_ch0", 32'(ch_out[0]), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ch_out", 32'(ch_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rearm_cfg_err", 32'(cfg_err), 32'd1);
        chk("rearm_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rearm_idle_busy", 32'(busy), 32'd0);
        chk("rearm_ch_out", 32'(ch_out), 32'd0);
        run = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pop_sequencer.md
POP_SEQUENCER -- requirements
Module: pop_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of timing channels (ch0 pump, ch1 probe, ch2 MW, ch3 sample).
REQ-002 SHALL have parameter WIDTH, default 16, width of the period counter and all timing registers.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port run  input  1  level; 1 = request sequencing, 0 = stop at end of current period.
REQ-006 SHALL have port single  input  1  1 = run cycle_count periods then stop; 0 = free-running.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-008 SHALL have port cfg_addr  input  8  register address: 0 period, 1 cycle_count, 2+2k start[k], 3+2k stop[k].
REQ-009 SHALL have port cfg_data  input  WIDTH  write data.
REQ-010 SHALL have port ch_out  output  NUM_CH  registered channel pulses.
REQ-011 SHALL have port busy  output  1  high in ARMED or RUN.
REQ-012 SHALL have port period_tick  output  1  one-cycle pulse when count = period-1.
REQ-013 SHALL have port cfg_err  output  1  sticky; set by out-of-range cfg_addr or period = 0 at arm; cleared by reset only.

Function
REQ-014 Writes SHALL go to shadow registers; shadows SHALL copy to active registers on entry to ARMED and at every period boundary.
REQ-015 FSM states SHALL be IDLE, ARMED, RUN, DONE.
REQ-016 IDLE -> ARMED when run = 1 and shadow period != 0; with shadow period = 0, stay IDLE and set cfg_err.
REQ-017 ARMED -> RUN on the next cycle, or per REQ-030 when the trigger feature is compiled in.
REQ-018 In RUN, count SHALL go 0 .. period-1 and wrap to 0.
REQ-019 At wrap, RUN -> IDLE if run = 0.
REQ-020 At wrap with single = 1, cycle counter SHALL decrement; when it reaches 0, RUN -> DONE; cycle_count = 0 SHALL mean one period.
REQ-021 DONE -> IDLE when run = 0.
REQ-022 For channel k, when start < stop, output SHALL be high for start <= count < stop.
REQ-023 When start > stop, output SHALL be high for count >= start or count < stop (wrap-around pulse).
REQ-024 When start = stop, output SHALL never be high.
REQ-025 Start/stop values >= period SHALL never match.
REQ-026 ch_out SHALL lag the count by exactly one clock, registered; all bits SHALL be 0 outside RUN.
REQ-027 A write coinciding with a boundary copy SHALL land in the shadow and take effect at the next boundary.

Reset
REQ-028 Reset asserted SHALL force state IDLE, count 0, ch_out 0, busy 0, period_tick 0, cfg_err 0, and all shadow and active registers 0, immediately and independent of clk.
REQ-029 Reset mid-RUN SHALL drop all outputs within the same cycle; after release the block SHALL wait in IDLE for a new run.

Configuration
REQ-030 With POP_SEQ_TRIG_EN defined, port trig (input, 1) SHALL exist, passing through a 2-flop synchroniser; ARMED -> RUN only on a synchronised rising edge; each period SHALL restart only on a further edge, with ch_out 0 while waiting.
REQ-031 Without POP_SEQ_TRIG_EN, no trig port SHALL exist and ARMED -> RUN after one cycle.

Structure
REQ-032 Package pop_seq_pkg SHALL hold the FSM state typedef, the cfg address constants (ADDR_PERIOD, ADDR_CYCLES, ADDR_CH_BASE) and the default NUM_CH/WIDTH.
REQ-033 Per-channel compare logic SHALL be sub-module pop_seq_channel (inputs count, start, stop, period, en; output pulse), instantiated NUM_CH times.

Verification
REQ-034 Period 400, start0/stop0 = 10/60, start3/stop3 = 300/310, run = 1 free: ch_out[0] high 50 cycles, starting 11 cycles after count 0; ch_out[3] high 10 cycles; period_tick every 400.
REQ-035 Period 100, start1 = 90, stop1 = 5: ch_out[1] high 15 cycles spanning the wrap; start2 = stop2 = 20: ch_out[2] stays 0.
REQ-036 single = 1, cycle_count = 3, period 50: exactly 3 period_ticks then DONE, busy 0, ch_out 0 until run drops.
REQ-037 Rewrite stop0 from 60 to 80 mid-period: current period keeps width 50, next period width 70.
REQ-038 Assert reset 37 cycles into RUN: ch_out and busy 0 before the next clk edge; run held high after release restarts with all registers 0, so cfg_err sets.
REQ-039 With POP_SEQ_TRIG_EN, trig edges 1000 cycles apart, period 400: one 400-cycle burst per edge, 2-3 cycle trig-to-count latency, ch_out 0 between bursts.
